stage_decode: RTL and testbench

- Second pipeline stage of the RV32I core; consumes the registered instruction, PC and PC+4 from the fetch stage.
- Contains the 32x32 integer register file, with write port driven by write-back and write-through bypass.
- Generates immediates and control signals; registers everything into the decode/execute pipeline register.
- Supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/stage_decode.sv | 210 +++++++++++++++++++++
 tb/tb_stage_decode.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/stage_decode.sv
// Decode stage of the RV32I pipeline: register file with write-through, immediate
// generation, control decode, and the decode/execute pipeline register.
module stage_decode #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_decode,
    input  logic            flush_decode,
    input  logic [31:0]     fetch_instr,
    input  logic [XLEN-1:0] fetch_instr_addr,
    input  logic [XLEN-1:0] fetch_instr_addr_plus,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] decode_instr_addr,
    output logic [XLEN-1:0] decode_instr_addr_plus,
    output logic [XLEN-1:0] decode_rs1_data,
    output logic [XLEN-1:0] decode_rs2_data,
    output logic [XLEN-1:0] decode_imm,
    output logic [4:0]      decode_rs1,
    output logic [4:0]      decode_rs2,
    output logic [4:0]      decode_rd,
    output logic [2:0]      decode_funct3,
    output logic [3:0]      decode_alu_ctrl,
    output logic            decode_alu_src,
    output logic            decode_alu_pc,
    output logic            decode_reg_write,
    output logic            decode_mem_read,
    output logic            decode_mem_write,
    output logic            decode_mem_to_reg,
    output logic            decode_branch,
    output logic            decode_jal,
    output logic            decode_jalr,
    output logic            decode_illegal
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                           OP_FENCE = 7'b0001111;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0] instr_addr;
        logic [XLEN-1:0] instr_addr_plus;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [3:0]      alu_ctrl;
        logic            alu_src;
        logic            alu_pc;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            illegal;
    } dx_t;

    logic [XLEN-1:0] regs_q [NREGS];
    dx_t             dec;
    dx_t             dx_d;
    dx_t             dx_q;

    // Each entry is its own flop set so that reset can clear the whole file at once.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
        always_ff @(posedge clk) begin
            if (rst)
                regs_q[gi] <= '0;
            else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == 5'(gi))
                regs_q[gi] <= wb_data;
        end
    end

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1, rs2;
    logic            wb_hit;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]      alu_arith;

    assign opcode = fetch_instr[6:0];
    assign funct3 = fetch_instr[14:12];
    assign funct7 = fetch_instr[31:25];
    assign rs1    = fetch_instr[19:15];
    assign rs2    = fetch_instr[24:20];
    assign wb_hit = wb_reg_write && (wb_rd != 5'd0);

    assign imm_i = {{20{fetch_instr[31]}}, fetch_instr[31:20]};
    assign imm_s = {{20{fetch_instr[31]}}, fetch_instr[31:25], fetch_instr[11:7]};
    assign imm_b = {{19{fetch_instr[31]}}, fetch_instr[31], fetch_instr[7], fetch_instr[30:25],
                    fetch_instr[11:8], 1'b0};
    assign imm_u = {fetch_instr[31:12], 12'h000};
    assign imm_j = {{11{fetch_instr[31]}}, fetch_instr[31], fetch_instr[19:12], fetch_instr[20],
                    fetch_instr[30:21], 1'b0};

    // instr[30] selects SUB only for register-register ops; ADDI with a negative imm must stay ADD.
    always_comb begin
        alu_arith = ALU_ADD;
        case (funct3)
            3'b000: alu_arith = (opcode == OP_REG && fetch_instr[30]) ? ALU_SUB : ALU_ADD;
            3'b001: alu_arith = ALU_SLL;
            3'b010: alu_arith = ALU_SLT;
            3'b011: alu_arith = ALU_SLTU;
            3'b100: alu_arith = ALU_XOR;
            3'b101: alu_arith = fetch_instr[30] ? ALU_SRA : ALU_SRL;
            3'b110: alu_arith = ALU_OR;
            default: alu_arith = ALU_AND;
        endcase
    end

    always_comb begin
        dec                 = '0;
        dec.instr_addr      = fetch_instr_addr;
        dec.instr_addr_plus = fetch_instr_addr_plus;
        dec.rs1             = rs1;
        dec.rs2             = rs2;
        dec.rd              = fetch_instr[11:7];
        dec.funct3          = funct3;
        dec.rs1_data        = (rs1 == 5'd0) ? '0 : ((wb_hit && wb_rd == rs1) ? wb_data : regs_q[rs1]);
        dec.rs2_data        = (rs2 == 5'd0) ? '0 : ((wb_hit && wb_rd == rs2) ? wb_data : regs_q[rs2]);
        case (opcode)
            OP_LUI:    begin dec.imm = imm_u; dec.alu_ctrl = ALU_PASS_B; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
            OP_AUIPC:  begin dec.imm = imm_u; dec.alu_pc = 1'b1; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
            OP_JAL:    begin dec.imm = imm_j; dec.jal = 1'b1; dec.reg_write = 1'b1; end
            OP_JALR:   begin dec.imm = imm_i; dec.jalr = 1'b1; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
            OP_BRANCH: begin dec.imm = imm_b; dec.branch = 1'b1; dec.alu_ctrl = ALU_SUB; end
            OP_LOAD: begin
                dec.imm = imm_i; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1;
                dec.alu_src = 1'b1; dec.reg_write = 1'b1;
            end
            OP_STORE:  begin dec.imm = imm_s; dec.mem_write = 1'b1; dec.alu_src = 1'b1; end
            OP_IMM: begin
                dec.imm = imm_i; dec.alu_ctrl = alu_arith; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
                    (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000))
                    dec.illegal = 1'b1;
            end
            OP_REG: begin
                dec.alu_ctrl = alu_arith; dec.reg_write = 1'b1;
                if (funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    dec.illegal = 1'b1;
            end
            OP_FENCE: ;
            default:  dec.illegal = 1'b1;
        endcase
        // Illegal encodings and the all-zero fetch bubble both decode to a NOP.
        if (dec.illegal || fetch_instr == 32'h0) begin
            dec.imm        = '0;
            dec.alu_ctrl   = ALU_ADD;
            dec.alu_src    = 1'b0;
            dec.alu_pc     = 1'b0;
            dec.reg_write  = 1'b0;
            dec.mem_read   = 1'b0;
            dec.mem_write  = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.branch     = 1'b0;
            dec.jal        = 1'b0;
            dec.jalr       = 1'b0;
            dec.illegal    = (fetch_instr != 32'h0);
        end
    end

    always_comb begin
        if (flush_decode)
            dx_d = '0;
        else if (stall_decode)
            dx_d = dx_q;
        else
            dx_d = dec;
    end

    always_ff @(posedge clk) begin
        if (rst)
            dx_q <= '0;
        else
            dx_q <= dx_d;
    end

    assign decode_instr_addr      = dx_q.instr_addr;
    assign decode_instr_addr_plus = dx_q.instr_addr_plus;
    assign decode_rs1_data        = dx_q.rs1_data;
    assign decode_rs2_data        = dx_q.rs2_data;
    assign decode_imm             = dx_q.imm;
    assign decode_rs1             = dx_q.rs1;
    assign decode_rs2             = dx_q.rs2;
    assign decode_rd              = dx_q.rd;
    assign decode_funct3          = dx_q.funct3;
    assign decode_alu_ctrl        = dx_q.alu_ctrl;
    assign decode_alu_src         = dx_q.alu_src;
    assign decode_alu_pc          = dx_q.alu_pc;
    assign decode_reg_write       = dx_q.reg_write;
    assign decode_mem_read        = dx_q.mem_read;
    assign decode_mem_write       = dx_q.mem_write;
    assign decode_mem_to_reg      = dx_q.mem_to_reg;
    assign decode_branch          = dx_q.branch;
    assign decode_jal             = dx_q.jal;
    assign decode_jalr            = dx_q.jalr;
    assign decode_illegal         = dx_q.illegal;
endmodule

// File: tb/tb_stage_decode.sv
// Scoreboard bench for stage_decode: directed instructions push hand-computed expectations,
// a negedge monitor pops and compares the full decode/execute bundle.
module tb_stage_decode;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_decode = 1'b0, flush_decode = 1'b0;
    logic [31:0] fetch_instr = 32'h0, fetch_instr_addr = 32'h0, fetch_instr_addr_plus = 32'h0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'h0;
    logic [31:0] decode_instr_addr, decode_instr_addr_plus, decode_rs1_data, decode_rs2_data, decode_imm;
    logic [4:0]  decode_rs1, decode_rs2, decode_rd;
    logic [2:0]  decode_funct3;
    logic [3:0]  decode_alu_ctrl;
    logic        decode_alu_src, decode_alu_pc, decode_reg_write, decode_mem_read, decode_mem_write;
    logic        decode_mem_to_reg, decode_branch, decode_jal, decode_jalr, decode_illegal;

    stage_decode dut (
        .clk(clk), .rst(rst), .stall_decode(stall_decode), .flush_decode(flush_decode),
        .fetch_instr(fetch_instr), .fetch_instr_addr(fetch_instr_addr),
        .fetch_instr_addr_plus(fetch_instr_addr_plus), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .decode_instr_addr(decode_instr_addr),
        .decode_instr_addr_plus(decode_instr_addr_plus), .decode_rs1_data(decode_rs1_data),
        .decode_rs2_data(decode_rs2_data), .decode_imm(decode_imm), .decode_rs1(decode_rs1),
        .decode_rs2(decode_rs2), .decode_rd(decode_rd), .decode_funct3(decode_funct3),
        .decode_alu_ctrl(decode_alu_ctrl), .decode_alu_src(decode_alu_src),
        .decode_alu_pc(decode_alu_pc), .decode_reg_write(decode_reg_write),
        .decode_mem_read(decode_mem_read), .decode_mem_write(decode_mem_write),
        .decode_mem_to_reg(decode_mem_to_reg), .decode_branch(decode_branch),
        .decode_jal(decode_jal), .decode_jalr(decode_jalr), .decode_illegal(decode_illegal)
    );

    always #5 clk = ~clk;

    // Control bit order: {alu_src, alu_pc, reg_write, mem_read, mem_write, mem_to_reg, branch, jal, jalr, illegal}
    localparam logic [9:0] C_SRC = 10'h200, C_PC = 10'h100, C_RW = 10'h080, C_MR = 10'h040,
                           C_MW = 10'h020, C_M2R = 10'h010, C_BR = 10'h008, C_JAL = 10'h004,
                           C_JALR = 10'h002, C_ILL = 10'h001, C_NONE = 10'h000;
    localparam int NORM = 0, ZERO = 1, HOLD = 2;

    typedef struct {
        logic [191:0] v;
        string        name;
    } exp_t;

    exp_t         sb[$];
    logic [191:0] last_exp = '0;
    logic [31:0]  pc = 32'h1000;
    int           checks = 0;
    int           errors = 0;

    wire [191:0] act = {decode_instr_addr, decode_instr_addr_plus, decode_rs1_data, decode_rs2_data,
                        decode_imm, decode_rs1, decode_rs2, decode_rd, decode_funct3, decode_alu_ctrl,
                        decode_alu_src, decode_alu_pc, decode_reg_write, decode_mem_read,
                        decode_mem_write, decode_mem_to_reg, decode_branch, decode_jal,
                        decode_jalr, decode_illegal};

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        wb_reg_write = en;
        wb_rd        = rd;
        wb_data      = data;
    endtask

    // One cycle of stimulus; rst/stall/flush/wb are set by the caller and cleared afterwards.
    task automatic issue(input string name, input logic [31:0] instr, input logic [31:0] rs1d,
                         input logic [31:0] rs2d, input logic [31:0] imm, input logic [3:0] alu,
                         input logic [9:0] ctl, input int kind);
        logic [191:0] e;
        exp_t         t;
        fetch_instr           = instr;
        fetch_instr_addr      = pc;
        fetch_instr_addr_plus = pc + 32'd4;
        case (kind)
            NORM:    e = {pc, pc + 32'd4, rs1d, rs2d, imm, instr[19:15], instr[24:20], instr[11:7],
                          instr[14:12], alu, ctl};
            ZERO:    e = '0;
            default: e = last_exp;
        endcase
        @(posedge clk);
        #1;
        t.v = e;
        t.name = name;
        sb.push_back(t);
        last_exp = e;
        pc = pc + 32'h10;
        rst = 1'b0; stall_decode = 1'b0; flush_decode = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
    endtask

    always begin
        @(negedge clk);
        if (sb.size() > 0) begin
            exp_t t;
            t = sb.pop_front();
            checks++;
            if (act !== t.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", t.name, act, t.v);
            end else begin
                $display("ok   %s: %h", t.name, act);
            end
        end
    end

    initial begin
        // Reset with a pending x7 write that must be discarded.
        rst = 1'b1; set_wb(1'b1, 5'd7, 32'h77);
        issue("reset0", 32'h00108113, 0, 0, 0, 0, C_NONE, ZERO);
        rst = 1'b1;
        issue("reset1", 32'h00108113, 0, 0, 0, 0, C_NONE, ZERO);
        issue("bubble_after_rst", 32'h0, 0, 0, 0, 0, C_NONE, NORM);
        set_wb(1'b1, 5'd1, 32'h5);
        issue("bubble_wb_x1", 32'h0, 0, 0, 0, 0, C_NONE, NORM);
        issue("addi_x2_x1_1", 32'h00108113, 32'h5, 32'h5, 32'h1, 4'd0, C_SRC | C_RW, NORM);
        set_wb(1'b1, 5'd5, 32'hDEADBEEF);
        issue("add_wt_x5", 32'h00528333, 32'hDEADBEEF, 32'hDEADBEEF, 0, 4'd0, C_RW, NORM);
        set_wb(1'b1, 5'd0, 32'hFFFFFFFF);
        issue("add_x0_wb_x0", 32'h00000333, 0, 0, 0, 4'd0, C_RW, NORM);
        issue("add_x5_x7_rstwr", 32'h007283B3, 32'hDEADBEEF, 0, 0, 4'd0, C_RW, NORM);
        issue("beq_m4", 32'hFE000EE3, 0, 0, 32'hFFFFFFFC, 4'd1, C_BR, NORM);
        issue("lui_x2", 32'h12345137, 0, 0, 32'h12345000, 4'd10, C_SRC | C_RW, NORM);
        issue("srai_x3", 32'h4020D193, 32'h5, 0, 32'h402, 4'd7, C_SRC | C_RW, NORM);
        issue("slli_bad_f7", 32'h40209193, 32'h5, 0, 0, 4'd0, C_ILL, NORM);
        issue("sub_x3", 32'h405081B3, 32'h5, 32'hDEADBEEF, 0, 4'd1, C_RW, NORM);
        issue("op_bad_f7", 32'h02000033, 0, 0, 0, 4'd0, C_ILL, NORM);
        issue("lw_m8", 32'hFF80A203, 32'h5, 0, 32'hFFFFFFF8, 4'd0, C_SRC | C_RW | C_MR | C_M2R, NORM);
        issue("sw_12", 32'h0050A623, 32'h5, 32'hDEADBEEF, 32'hC, 4'd0, C_SRC | C_MW, NORM);
        issue("jal_16", 32'h010000EF, 0, 0, 32'h10, 4'd0, C_JAL | C_RW, NORM);
        issue("jalr_x1", 32'h00008067, 32'h5, 0, 0, 4'd0, C_JALR | C_SRC | C_RW, NORM);
        issue("auipc_1", 32'h00001117, 0, 0, 32'h1000, 4'd0, C_PC | C_SRC | C_RW, NORM);
        issue("fence", 32'h0000000F, 0, 0, 0, 4'd0, C_NONE, NORM);
        // Stall holds outputs while the register file keeps accepting writes.
        issue("addi_pre_stall", 32'h00108113, 32'h5, 32'h5, 32'h1, 4'd0, C_SRC | C_RW, NORM);
        stall_decode = 1'b1; set_wb(1'b1, 5'd8, 32'h88);
        issue("stall1", 32'hFFFFFFFF, 0, 0, 0, 0, C_NONE, HOLD);
        stall_decode = 1'b1;
        issue("stall2", 32'hFFFFFFFF, 0, 0, 0, 0, C_NONE, HOLD);
        stall_decode = 1'b1;
        issue("stall3", 32'hFFFFFFFF, 0, 0, 0, 0, C_NONE, HOLD);
        stall_decode = 1'b1; flush_decode = 1'b1;
        issue("flush_over_stall", 32'h00108113, 0, 0, 0, 0, C_NONE, ZERO);
        issue("lui_reads_x8", 32'h12345137, 32'h88, 0, 32'h12345000, 4'd10, C_SRC | C_RW, NORM);
        issue("all_ones_illegal", 32'hFFFFFFFF, 0, 0, 0, 4'd0, C_ILL, NORM);
        issue("zero_bubble", 32'h00000000, 0, 0, 0, 4'd0, C_NONE, NORM);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
